btb_predictor: RTL

Parametrised direct-mapped branch target buffer that replaces the fixed 32-entry, 16-bit predictor. Each entry holds a tag, a target and an N-bit saturating counter. A registered lookup port serves fetch, and an update port serves branch resolution. A sequential sweep FSM clears the table after reset and on flush, so the table needs no reset fan-out.

---
 rtl/btb_predictor.sv | 117 +++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with a registered lookup port, an update port
// and a sweep FSM that clears the valid bits after reset and on flush.
module btb_predictor #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 5,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic            alloc,
    output logic            evict,
    input  logic            flush_req,
    output logic            busy
);
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [PC_W-1:0]    targets [ENTRIES];
    logic [CNT_W-1:0]   ctrs    [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            state_nx = flush_req ? FLUSH : IDLE;
            ptr_nx   = '0;
        end else begin
            ptr_nx = ptr + 1'b1;
            if (&ptr) state_nx = IDLE;
        end
    end

    assign busy = state != IDLE;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic [CNT_W-1:0] u_ctr;
    logic             l_hit, u_vld, u_match, u_new;

    assign l_idx   = lookup_pc[IDX_W-1:0];
    assign l_tag   = lookup_pc[PC_W-1:IDX_W];
    assign u_idx   = upd_pc[IDX_W-1:0];
    assign u_tag   = upd_pc[PC_W-1:IDX_W];
    assign u_ctr   = ctrs[u_idx];
    assign l_hit   = !busy && valid[l_idx] && tags[l_idx] == l_tag;
    assign u_vld   = valid[u_idx];
    assign u_match = u_vld && tags[u_idx] == u_tag;
    assign u_new   = !busy && upd_valid && upd_taken && !u_match;

    // Table has no reset; the sweep owns valid while busy, updates own it otherwise.
    always_ff @(posedge clk) begin
        if (busy) begin
            valid[ptr] <= 1'b0;
        end else if (upd_valid) begin
            if (u_match) begin
                if (upd_taken) begin
                    targets[u_idx] <= upd_target;
                    if (u_ctr != '1) ctrs[u_idx] <= u_ctr + 1'b1;
                end else if (u_ctr != '0) begin
                    ctrs[u_idx] <= u_ctr - 1'b1;
                end
            end else if (upd_taken) begin
                valid[u_idx]   <= 1'b1;
                tags[u_idx]    <= u_tag;
                targets[u_idx] <= upd_target;
                ctrs[u_idx]    <= CNT_W'(1) << (CNT_W - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '1;
            alloc       <= 1'b0;
            evict       <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                pred_hit    <= l_hit;
                pred_taken  <= l_hit && ctrs[l_idx][CNT_W-1];
                pred_target <= l_hit ? targets[l_idx] : '1;
            end
            alloc <= u_new && !u_vld;
            evict <= u_new && u_vld;
        end
    end
endmodule
